// File: rtl/button_debounce.sv
// Two-flop synchroniser and debounce FSM giving a clean level, press/release/long pulses and a 16-bit press count.
// Define BUTTON_DEBOUNCE_AUTOREPEAT_EN to re-fire press_pulse every REPEAT_CYCLES after a long press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_in,
  input  logic        clr,
  output logic        btn_level,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic        long_pulse,
  output logic [15:0] data
);

  localparam int CNT_MAX = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG = CNT_W'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES/REPEAT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic             s1, btn_sync;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             long_done, long_done_n;
  logic             level_n, press_n, release_n, long_n;
  logic [15:0]      data_n;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP = REP_W'(REPEAT_CYCLES);
  logic [REP_W-1:0] rep, rep_n;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    long_done_n = long_done;
    level_n     = btn_level;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    rep_n       = '0;
`endif
    case (state)
      IDLE: begin
        level_n = 1'b0;
        if (btn_sync) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= DEB) begin
          state_n     = PRESSED;
          cnt_n       = '0;
          level_n     = 1'b1;
          press_n     = 1'b1;
          long_done_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_W'(1);
        end else begin
          if (cnt < LONG) begin
            cnt_n = cnt + 1'b1;
            // long_done keeps a bounced release from producing a second long pulse
            if (cnt_n == LONG && !long_done) begin
              long_n      = 1'b1;
              long_done_n = 1'b1;
            end
          end
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
          if (long_done) begin
            rep_n = rep + 1'b1;
            if (rep_n == REP) begin
              press_n = 1'b1;
              rep_n   = '0;
            end
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt >= DEB) begin
          state_n   = IDLE;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // clear has priority over a coincident press
    if (clr)          data_n = '0;
    else if (press_n) data_n = data + 16'd1;
    else              data_n = data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= 1'b0;
      btn_sync      <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      data          <= '0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
      rep           <= '0;
`endif
    end else begin
      s1            <= btn_in;
      btn_sync      <= s1;
      state         <= state_n;
      cnt           <= cnt_n;
      long_done     <= long_done_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
      data          <= data_n;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
      rep           <= rep_n;
`endif
    end
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioning stage for the push-button path: synchronises a raw mechanical button and debounces it.
- Emits a clean level plus single-cycle press, release and long-press pulses.
- Maintains a 16-bit press-event count on `data`, which drives hex_display's `data` input directly in place of the free-running counter.
- Runs on the fast board clock; no divided clock is needed.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (>=2)
- LONG_CYCLES, 64, cycles the debounced level must stay high after the press pulse before long_pulse fires (>DEBOUNCE_CYCLES)
- REPEAT_CYCLES, 32, auto-repeat period in cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset, synchronous deassertion assumed by the environment
- btn_in  input  1  raw asynchronous button, active high
- clr  input  1  synchronous clear of the press count
- btn_level  output  1  debounced button level
- press_pulse  output  1  one-cycle pulse on accepted press (and on each auto-repeat)
- release_pulse  output  1  one-cycle pulse on accepted release
- long_pulse  output  1  one-cycle pulse when the press has been held LONG_CYCLES
- data  output  16  press count, feeds hex_display

Behaviour:
- Reset (rst_n=0, immediate, asynchronous):
  - All outputs go to 0: btn_level, press_pulse, release_pulse, long_pulse, data=16'h0000.
  - Synchroniser flops cleared; FSM forced to IDLE; all counters cleared.
- Synchroniser:
  - Two flops, btn_in -> s1 -> btn_sync.
  - Only btn_sync is used downstream.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. One stability counter, width clog2(max(LONG_CYCLES,DEBOUNCE_CYCLES)+1).
- IDLE:
  - btn_sync=1 -> PRESS_WAIT with cnt=1.
  - Otherwise stay; btn_level=0.
- PRESS_WAIT:
  - btn_sync=0 -> IDLE, cnt=0. Glitch rejected, no pulse.
  - btn_sync=1 and cnt<DEBOUNCE_CYCLES -> cnt++.
  - On the edge where btn_sync=1 and cnt=DEBOUNCE_CYCLES -> PRESSED, btn_level=1, press_pulse=1 for one cycle, data++, cnt=0.
- PRESSED:
  - cnt increments, saturating at LONG_CYCLES.
  - When cnt reaches LONG_CYCLES, long_pulse=1 for exactly one cycle; at most one long_pulse per press.
  - btn_sync=0 -> RELEASE_WAIT with cnt=1, and the long-hold count is discarded.
- RELEASE_WAIT:
  - Mirror of PRESS_WAIT on btn_sync=0.
  - btn_sync=1 before acceptance -> back to PRESSED, with the long count restarting from 0 and no new press_pulse.
  - On acceptance -> IDLE, btn_level=0, release_pulse=1 for one cycle.
- Latency: press_pulse registered high DEBOUNCE_CYCLES+2 clock edges after the first edge that samples btn_in=1, with btn_in held stable. Release latency is identical.
- Pulses are registered outputs, never high for two consecutive cycles except auto-repeat with REPEAT_CYCLES=1, which is disallowed (REPEAT_CYCLES>=2).
- data:
  - Unsigned 16-bit, increments by 1 per press_pulse, wraps 16'hFFFF -> 16'h0000.
  - clr=1 sets data=0 next edge. clr and press_pulse in the same cycle -> clr wins, data=0.
- Reset mid-operation: any state returns to IDLE.
  - If btn_in is still high after rst_n rises, it is treated as a fresh press: new press_pulse after DEBOUNCE_CYCLES+2 edges, and data counts it from 0.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_AUTOREPEAT_EN.
- Defined: after long_pulse, while in PRESSED, press_pulse re-fires and data increments every REPEAT_CYCLES cycles until btn_sync drops. The first repeat is REPEAT_CYCLES cycles after long_pulse. A repeat counter runs in PRESSED only and is cleared on leaving it.
- Undefined: no repeat logic is instantiated; exactly one press_pulse per accepted press; REPEAT_CYCLES is ignored.

Test Plan (all with DEBOUNCE_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=8):
- Clean press: btn_in 0->1, held 10 cycles -> press_pulse high for one cycle 6 edges after the first sampling edge, btn_level=1, data 0->1; on release, release_pulse 6 edges later and btn_level=0.
- Bounce rejection: btn_in pulses 1 for 3 cycles, 0 for 2, then 1 for 2, then 0 -> no pulse, btn_level stays 0, data stays 0.
- Long press: hold 40 cycles -> exactly one press_pulse and exactly one long_pulse, 16 cycles after press_pulse. Without the macro, data=1. With the macro, additional press_pulses at 8-cycle spacing after long_pulse and data counts them.
- Wrap and clear: preload via 65535 presses (or force), one more press -> data=0x0000. Assert clr coincident with a press_pulse -> data=0.
- Release bounce: while pressed, btn_in drops for 2 cycles then returns -> no release_pulse, btn_level stays 1, no second press_pulse.
- Async reset mid-press: pull rst_n low with btn_in held high in PRESSED -> all outputs 0 immediately. After rst_n rises with btn_in still high -> press_pulse after 6 edges, data=1.
